// File: rtl/axi_pkg.sv
// AXI helper package for the read-response buffer.
//   resp_e    : AXI RRESP encoding
//   AXI_LEN_W : width of arlen / burst beat counter
package axi_pkg;
  localparam int AXI_LEN_W = 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push_i     : write wdata_i (ignored when full)
//   pop_i      : drop head entry (ignored when empty)
//   rdata_o    : head entry, valid whenever !empty_o
//   full_o, empty_o, count_o : registered occupancy flags / count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only observed when count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/read_resp_fifo.sv
// AXI4 R-channel response buffer. Burst commands (id, len) and cache data
// beats are queued independently and merged into R beats with rid/rlast/rresp.
//   cmd_*   : burst command push (id from arid, len from arlen)
//   beat_*  : data beat push from the cache datapath
//   r*      : AXI R channel toward the interconnect
//   data_count : beats currently held in the data FIFO
module read_resp_fifo
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 8,
  parameter int CMD_DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [ID_WIDTH-1:0]        cmd_id,
  input  logic [AXI_LEN_W-1:0]       cmd_len,
  input  logic                       beat_valid,
  output logic                       beat_ready,
  input  logic [DATA_WIDTH-1:0]      beat_data,
  input  logic [1:0]                 beat_resp,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [ID_WIDTH-1:0]        rid,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic [1:0]                 rresp,
  output logic                       rlast,
  output logic [$clog2(DEPTH+1)-1:0] data_count
);
  localparam int CMD_W = ID_WIDTH + AXI_LEN_W;
  localparam int DAT_W = DATA_WIDTH + 2;

  logic [CMD_W-1:0]                 c_head;
  logic                             c_full, c_empty;
  logic [$clog2(CMD_DEPTH+1)-1:0]   c_count;
  logic [DAT_W-1:0]                 d_head;
  logic                             d_full, d_empty;

  logic [AXI_LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [AXI_LEN_W-1:0]  head_len;
  logic [ID_WIDTH-1:0]   head_id;
  resp_e                 head_resp;
  logic                  head_last;
  logic                  fire;

  // Readies come from registered occupancy only.
  assign cmd_ready  = !c_full;
  assign beat_ready = !d_full;

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_valid && cmd_ready),
    .wdata_i ({cmd_id, cmd_len}),
    .pop_i   (fire && head_last),
    .rdata_o (c_head),
    .full_o  (c_full),
    .empty_o (c_empty),
    .count_o (c_count)
  );

  sync_fifo #(.WIDTH(DAT_W), .DEPTH(DEPTH)) u_dat_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (beat_valid && beat_ready),
    .wdata_i ({beat_resp, beat_data}),
    .pop_i   (fire),
    .rdata_o (d_head),
    .full_o  (d_full),
    .empty_o (d_empty),
    .count_o (data_count)
  );

  assign head_id   = c_head[AXI_LEN_W +: ID_WIDTH];
  assign head_len  = c_head[AXI_LEN_W-1:0];
  assign head_resp = resp_e'(d_head[DATA_WIDTH +: 2]);

  assign rvalid    = !d_empty && !c_empty;
  assign head_last = (beat_cnt_q == head_len);
  assign fire      = rvalid && rready;

  // Outputs are zeroed when idle so nothing stale leaks onto the bus.
  assign rid   = rvalid ? head_id : '0;
  assign rdata = rvalid ? d_head[DATA_WIDTH-1:0] : '0;
  assign rresp = rvalid ? head_resp : OKAY;
  assign rlast = rvalid && head_last;

  // Counter clears on the last beat, so len=255 tops out at 255 without wrapping.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (fire) beat_cnt_d = head_last ? '0 : beat_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) beat_cnt_q <= '0;
    else        beat_cnt_q <= beat_cnt_d;
  end
endmodule

// File: tb/tb_read_resp_fifo.sv
module tb_read_resp_fifo;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_id;
  logic [7:0]  cmd_len;
  logic        beat_valid, beat_ready;
  logic [63:0] beat_data;
  logic [1:0]  beat_resp;
  logic        rvalid, rready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  data_count;

  typedef struct {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // hold-while-stalled tracking
  logic        stall = 1'b0;
  logic [3:0]  s_id;
  logic [63:0] s_data;
  logic [1:0]  s_resp;
  logic        s_last;

  always #5 clk = ~clk;

  read_resp_fifo #(.DATA_WIDTH(64), .ID_WIDTH(4), .DEPTH(8), .CMD_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_len(cmd_len),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_data(beat_data), .beat_resp(beat_resp),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .data_count(data_count)
  );

  // Scoreboard: every R fire is compared with the next expected beat.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        n_vec++;
        if (rvalid !== 1'b1 || rid !== s_id || rdata !== s_data || rresp !== s_resp || rlast !== s_last) begin
          n_err++;
          $display("FAIL hold: got v=%b id=%h d=%h r=%b l=%b want v=1 id=%h d=%h r=%b l=%b",
                   rvalid, rid, rdata, rresp, rlast, s_id, s_data, s_resp, s_last);
        end
      end
      stall = (rvalid === 1'b1) && (rready === 1'b0);
      s_id = rid; s_data = rdata; s_resp = rresp; s_last = rlast;
      if (rvalid === 1'b1 && rready === 1'b1) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: got id=%h d=%h, want none", rid, rdata);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (rid !== e.id || rdata !== e.data || rresp !== e.resp || rlast !== e.last) begin
            n_err++;
            $display("FAIL rbeat: got id=%h d=%h r=%b l=%b want id=%h d=%h r=%b l=%b",
                     rid, rdata, rresp, rlast, e.id, e.data, e.resp, e.last);
          end
        end
      end
    end
  end

  task automatic expect_beat(input logic [3:0] id, input logic [63:0] d, input logic [1:0] r, input logic l);
    exp_t e;
    e.id = id; e.data = d; e.resp = r; e.last = l;
    q.push_back(e);
  endtask

  task automatic push_cmd(input logic [3:0] id, input logic [7:0] len);
    bit done = 0;
    cmd_valid = 1'b1; cmd_id = id; cmd_len = len;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) done = 1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL cmd_timeout: cmd_ready stayed %b, want 1", cmd_ready);
    end
  endtask

  task automatic push_beat(input logic [63:0] d, input logic [1:0] r);
    bit done = 0;
    beat_valid = 1'b1; beat_data = d; beat_resp = r;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (beat_ready === 1'b1) done = 1;
      @(posedge clk); #1;
    end
    beat_valid = 1'b0;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL beat_timeout: beat_ready stayed %b, want 1", beat_ready);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d beats outstanding, want 0", q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (rvalid !== 1'b0 || rlast !== 1'b0 || rid !== 4'h0 || rdata !== 64'h0 || rresp !== 2'b00) begin
      n_err++;
      $display("FAIL reset_out: got v=%b l=%b id=%h d=%h r=%b want all 0", rvalid, rlast, rid, rdata, rresp);
    end
    n_vec++;
    if (data_count !== 4'd0 || cmd_ready !== 1'b1 || beat_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got cnt=%0d cr=%b br=%b want 0 1 1", data_count, cmd_ready, beat_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    rready = 1'b1;
    expect_beat(4'd3, 64'hA5, 2'b00, 1'b1);
    push_cmd(4'd3, 8'd0);
    push_beat(64'hA5, 2'b00);
    wait_drain();
    @(negedge clk);
    n_vec++;
    if (rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle: rvalid=%b want 0", rvalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_burst_backpressure();
    rready = 1'b0;
    for (int i = 0; i < 4; i++) expect_beat(4'd1, 64'h10 + 64'(i), 2'b00, i == 3);
    push_cmd(4'd1, 8'd3);
    for (int i = 0; i < 4; i++) push_beat(64'h10 + 64'(i), 2'b00);
    rready = 1'b1;
    @(posedge clk); @(posedge clk);
    #1 rready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (rvalid !== 1'b1 || rdata !== 64'h12 || rlast !== 1'b0) begin
      n_err++;
      $display("FAIL burst_stall: got v=%b d=%h l=%b want 1 12 0", rvalid, rdata, rlast);
    end
    @(negedge clk);
    @(posedge clk); #1;
    rready = 1'b1;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    rready = 1'b0;
    expect_beat(4'd1, 64'h21, 2'b00, 1'b0);
    expect_beat(4'd1, 64'h22, 2'b00, 1'b1);
    expect_beat(4'd2, 64'h23, 2'b00, 1'b1);
    push_cmd(4'd1, 8'd1);
    push_cmd(4'd2, 8'd0);
    for (int i = 1; i <= 3; i++) push_beat(64'h20 + 64'(i), 2'b00);
    rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (rvalid !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_gap: beat %0d rvalid=%b want 1", i, rvalid);
      end
    end
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_full();
    rready = 1'b0;
    for (int i = 0; i < 8; i++) expect_beat(4'd7, 64'h30 + 64'(i), 2'b00, i == 7);
    push_cmd(4'd7, 8'd7);
    for (int i = 0; i < 8; i++) push_beat(64'h30 + 64'(i), 2'b00);
    @(negedge clk);
    n_vec++;
    if (data_count !== 4'd8 || beat_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_flags: got cnt=%0d br=%b want 8 0", data_count, beat_ready);
    end
    @(posedge clk); #1;
    beat_valid = 1'b1; beat_data = 64'hDEAD; beat_resp = 2'b00;
    @(posedge clk); #1;
    beat_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (data_count !== 4'd8) begin
      n_err++;
      $display("FAIL full_reject: cnt=%0d want 8", data_count);
    end
    @(posedge clk); #1;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (beat_ready !== 1'b1 || data_count !== 4'd7) begin
      n_err++;
      $display("FAIL full_release: got br=%b cnt=%0d want 1 7", beat_ready, data_count);
    end
    @(posedge clk); #1;
    rready = 1'b1;
    wait_drain();
  endtask

  task automatic test_data_before_cmd();
    rready = 1'b1;
    push_beat(64'h50, 2'b00);
    push_beat(64'h51, 2'b10);
    @(negedge clk);
    n_vec++;
    if (rvalid !== 1'b0 || data_count !== 4'd2) begin
      n_err++;
      $display("FAIL early_data: got v=%b cnt=%0d want 0 2", rvalid, data_count);
    end
    @(posedge clk); #1;
    expect_beat(4'd5, 64'h50, 2'b00, 1'b0);
    expect_beat(4'd5, 64'h51, 2'b10, 1'b1);
    push_cmd(4'd5, 8'd1);
    @(negedge clk);
    n_vec++;
    if (rvalid !== 1'b1) begin
      n_err++;
      $display("FAIL cmd_arrive: rvalid=%b want 1", rvalid);
    end
    wait_drain();
  endtask

  task automatic test_long_burst();
    rready = 1'b1;
    for (int i = 0; i < 256; i++) expect_beat(4'd4, 64'h1000 + 64'(i), 2'(i), i == 255);
    push_cmd(4'd4, 8'd255);
    for (int i = 0; i < 256; i++) push_beat(64'h1000 + 64'(i), 2'(i));
    wait_drain();
    @(negedge clk);
    n_vec++;
    if (rvalid !== 1'b0 || data_count !== 4'd0) begin
      n_err++;
      $display("FAIL long_end: got v=%b cnt=%0d want 0 0", rvalid, data_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_burst();
    rready = 1'b1;
    expect_beat(4'd6, 64'h60, 2'b00, 1'b0);
    expect_beat(4'd6, 64'h61, 2'b00, 1'b0);
    push_cmd(4'd6, 8'd3);
    push_beat(64'h60, 2'b00);
    push_beat(64'h61, 2'b00);
    wait_drain();
    rready = 1'b0;
    push_beat(64'h62, 2'b00);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (rvalid !== 1'b0 || data_count !== 4'd0) begin
      n_err++;
      $display("FAIL mid_reset: got v=%b cnt=%0d want 0 0", rvalid, data_count);
    end
    @(posedge clk); #1;
    rready = 1'b1;
    expect_beat(4'd9, 64'hEE, 2'b00, 1'b1);
    push_cmd(4'd9, 8'd0);
    push_beat(64'hEE, 2'b00);
    wait_drain();
  endtask

  initial begin
    rst_n = 1'b0; rready = 1'b0;
    cmd_valid = 1'b0; cmd_id = '0; cmd_len = '0;
    beat_valid = 1'b0; beat_data = '0; beat_resp = '0;
    test_reset();
    test_single();
    test_burst_backpressure();
    test_back_to_back();
    test_full();
    test_data_before_cmd();
    test_long_burst();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
